// File: rtl/icache_ro_direct_if.sv
// Bus bundle for the read-only instruction cache: pipeline fetch port plus slow_memI block port.
// The cache takes the slave view; the pipeline/memory side (or a bench) takes the master view.
interface icache_ro_direct_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_ro_direct.sv
// Read-only direct-mapped instruction cache, 4-word lines, refilled from slow_memI on a miss.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_ro_direct #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25   // must equal 28-INDEX_W
) (
  input  logic clk,
  input  logic rst_n,
  icache_ro_direct_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int NBLK = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, ALLOC, FILL} state_t;

  state_t             state_reg, state_next;
  logic [NBLK-1:0]    valid_reg;
  logic [NBLK-1:0]    fill_sel;
  logic [TAG_W-1:0]   tag_mem  [NBLK];
  logic [127:0]       data_mem [NBLK];
  logic               mem_read_reg, mem_read_next;
  logic [27:0]        mem_addr_reg, mem_addr_next;
  logic               fill_we;
  logic               miss_start;
  logic               hit;
  logic               stall;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               unused_ok;

  assign idx      = bus.proc_addr[INDEX_W+1:2];
  assign tag      = bus.proc_addr[29:INDEX_W+2];
  assign word     = bus.proc_addr[1:0];
  assign fill_idx = mem_addr_reg[INDEX_W-1:0];
  assign fill_tag = mem_addr_reg[27:INDEX_W];

  // The write path has no function in a read-only cache.
  assign unused_ok = ^{bus.proc_write, bus.proc_wdata};

  assign hit            = valid_reg[idx] & (tag_mem[idx] == tag);
  assign bus.proc_rdata = data_mem[idx][32*word +: 32];
  assign bus.proc_stall = stall;
  assign bus.mem_read   = mem_read_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = '0;

  always_comb begin
    state_next    = state_reg;
    mem_read_next = mem_read_reg;
    mem_addr_next = mem_addr_reg;
    stall         = 1'b0;
    fill_we       = 1'b0;
    miss_start    = 1'b0;
    case (state_reg)
      IDLE: begin
        stall = bus.proc_read & ~hit;
        if (bus.proc_read && !hit) begin
          mem_addr_next = bus.proc_addr[29:2];
          mem_read_next = 1'b1;
          miss_start    = 1'b1;
          state_next    = ALLOC;
        end
      end
      ALLOC: begin
        stall = 1'b1;
        if (bus.mem_ready) begin
          fill_we       = 1'b1;
          mem_read_next = 1'b0;
          state_next    = FILL;
        end
      end
      FILL: begin
        stall      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mem_read_reg <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mem_read_reg <= mem_read_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  // One-hot line select for the refill; the refill always targets the latched block address.
  for (genvar gi = 0; gi < NBLK; gi++) begin : g_fill_sel
    assign fill_sel[gi] = fill_we & (fill_idx == INDEX_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_reg | fill_sel;
    end
  end

  // Line payload carries no reset; the valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_idx] <= bus.mem_rdata;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (state_reg == IDLE && bus.proc_read && hit) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (miss_start) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_icache_ro_direct.sv
// Scoreboard bench for icache_ro_direct: random fetches checked against a block-level cache model.
// Define ICACHE_PERF_CNT_EN to also check the hit/miss counters.
module tb_icache_ro_direct;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_ro_direct_if bus();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_ro_direct dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          passes = 0;
  int          accepted = 0;
  int          stall_cnt = 0;
  int          mem_lat = 1;
  logic [27:0] exp_maddr = '0;
  bit          stray_req = 0;
  bit          mon_en = 0;
  int          rcnt = 0;

  // Model: which block address each line holds (-1 = empty), plus counter expectations.
  longint      m_blk[8];
  int          m_hit = 0;
  int          m_miss = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] blk(input logic [27:0] b);
    logic [127:0] r;
    if (b == 28'h1) return 128'h44444444_33333333_22222222_11111111;
    for (int w = 0; w < 4; w++)
      r[32*w +: 32] = (32'(b) * 32'h9E3779B1) ^ (32'(w) * 32'h01010101) ^ 32'h5A5A0000;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_blk[i] = -1;
    m_hit = 0;
    m_miss = 0;
  endtask

  task automatic summary_and_finish();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  // Memory responder: ready arrives lat cycles after mem_read rises (sampled on that edge).
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        stray_req     = 0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '1;
      end else if (bus.mem_read) begin
        rcnt++;
        chk("mem_addr", bus.mem_addr, exp_maddr);
        if (rcnt == mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = blk(bus.mem_addr);
        end else begin
          bus.mem_ready = 1'b0;
        end
      end else begin
        rcnt          = 0;
        bus.mem_ready = 1'b0;
      end
    end
  end

  // Monitor: counts stall cycles and checks each accepted fetch against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.proc_read) begin
          if (bus.proc_stall) begin
            stall_cnt++;
          end else if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_accept: addr %0h accepted with no fetch pending", bus.proc_addr);
          end else begin
            e = sbq.pop_front();
            chk("rdata", bus.proc_rdata, e.data);
            chk("stall_cycles", stall_cnt, e.stalls);
            if (e.stalls == 0) chk("hit_no_mem_read", bus.mem_read, 1'b0);
            $display("fetch addr=%08h data=%08h stalls=%0d", e.addr, bus.proc_rdata, stall_cnt);
            stall_cnt = 0;
            accepted++;
          end
        end else begin
          chk("idle_stall", bus.proc_stall, 1'b0);
          chk("mem_write_tied", {bus.mem_write, bus.mem_wdata}, '0);
        end
      end
    end
  end

  task automatic fetch(input logic [29:0] addr, input int lat);
    exp_t         e;
    logic [27:0]  b;
    logic [127:0] line;
    int           idx;
    int           a0;
    b     = addr[29:2];
    idx   = int'(b[2:0]);
    line  = blk(b);
    e.addr = addr;
    e.data = line[32*addr[1:0] +: 32];
    if (m_blk[idx] == longint'(b)) begin
      e.stalls = 0;
    end else begin
      e.stalls   = lat + 2;
      m_blk[idx] = longint'(b);
      m_miss++;
    end
    m_hit++;
    sbq.push_back(e);
    exp_maddr      = b;
    mem_lat        = lat;
    a0             = accepted;
    bus.proc_read  = 1'b1;
    bus.proc_addr  = addr;
    bus.proc_write = 1'($urandom);
    bus.proc_wdata = $urandom;
    for (int t = 0; t < 40 && accepted == a0; t++) @(posedge clk);
    #1;
    if (accepted == a0) begin
      checks++;
      $display("FAIL fetch_timeout: addr %0h not accepted within 40 cycles", addr);
      summary_and_finish();
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_CNT_EN
    chk({tag, "_hit_cnt"}, hit_cnt, 32'(m_hit));
    chk({tag, "_miss_cnt"}, miss_cnt, 32'(m_miss));
`endif
  endtask

  initial begin
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 28'h0);
    chk("rst_stall_noread", bus.proc_stall, 1'b0);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h5;
    #1;
    chk("rst_stall_read", bus.proc_stall, 1'b1);
    bus.proc_read = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Cold miss, then hits on the same line
    fetch(30'h5, 3);
    fetch(30'h4, 1);
    fetch(30'h6, 1);
    fetch(30'h7, 1);
    check_counters("directed");

    // Conflict on index 1
    fetch(30'h24, 2);
    fetch(30'h4, 2);

    // Stray ready in IDLE; untouched lines must stay invalid
    idle_cycles(1);
    stray_req = 1;
    idle_cycles(3);
    fetch(30'h4, 1);
    fetch(30'h10, 2);

    // Reset two cycles into a refill
    mon_en        = 0;
    exp_maddr     = 28'h12;
    mem_lat       = 20;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h48;
    for (int t = 0; t < 10 && !bus.mem_read; t++) @(posedge clk);
    chk("alloc_entered", bus.mem_read, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_alloc_mem_read", bus.mem_read, 1'b0);
    chk("rst_alloc_mem_addr", bus.mem_addr, 28'h0);
    chk("rst_alloc_stall", bus.proc_stall, 1'b1);
    model_clear();
    sbq.delete();
    bus.proc_read = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    stray_req = 1;
    idle_cycles(3);
    stall_cnt = 0;
    mon_en    = 1;
    fetch(30'h48, 2);
    fetch(30'h5, 1);

    // Random traffic over 32 blocks (4 tags per line) with random latency and gaps
    for (int n = 0; n < 300; n++) begin
      fetch(30'($urandom_range(0, 127)), int'($urandom_range(1, 5)));
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end
    idle_cycles(2);
    check_counters("final");
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    summary_and_finish();
  end

endmodule
